// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 exception/interrupt sequencer (IDLE->FLUSH->COMMIT, IDLE->RET).
// Ports: exc_* / irq_in / timer_pending in; CAUSE/EPC/STATUS strobes, flush, redirect out.
// Option: define CP0_IRQ_SYNC_EN to add a synchronizer flop on irq_in[6:0].
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_adel,
  input  logic        exc_ades,
  input  logic        exc_ri,
  input  logic        exc_ov,
  input  logic        exc_sys,
  input  logic        exc_bp,
  input  logic [31:0] exc_pc,
  input  logic [6:0]  irq_in,
  input  logic        timer_pending,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic [7:0]  status_im,
  input  logic        eret,
  input  logic [31:0] epc_in,
  output logic [7:0]  interrupts,
  output logic        activeexception,
  output logic [4:0]  exccode,
  output logic        epc_we,
  output logic [31:0] epc_wdata,
  output logic        set_exl,
  output logic        clr_exl,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    COMMIT,
    RET
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [4:0]  code_q;
  logic [4:0]  exccode_q;
  logic [31:0] pc_q;
  logic [4:0]  sel_code;
  logic        sync_req;
  logic        int_take;
  logic        take;
  logic [6:0]  irq_stage;

`ifdef CP0_IRQ_SYNC_EN
  // First synchronizer flop; the interrupts register is the second.
  logic [6:0] irq_s;

  always_ff @(posedge clk) begin
    if (reset) irq_s <= '0;
    else       irq_s <= irq_in;
  end

  assign irq_stage = irq_s;
`else
  assign irq_stage = irq_in;
`endif

  assign sync_req = exc_adel | exc_ades | exc_ri
                  | exc_ov | exc_sys | exc_bp;

  assign int_take = status_ie & ~status_exl
                  & (|(interrupts & status_im));

  assign take = sync_req | int_take;

  always_comb begin
    sel_code = 5'd0;
    if (exc_adel)     sel_code = 5'd4;
    else if (exc_ades) sel_code = 5'd5;
    else if (exc_ri)   sel_code = 5'd10;
    else if (exc_ov)   sel_code = 5'd12;
    else if (exc_sys)  sel_code = 5'd8;
    else if (exc_bp)   sel_code = 5'd9;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      code_q     <= '0;
      pc_q       <= '0;
      exccode_q  <= '0;
      interrupts <= '0;
    end else begin
      state      <= state_nx;
      interrupts <= {timer_pending, irq_stage};
      if (state == IDLE && take) begin
        code_q <= sel_code;
        pc_q   <= exc_pc;
      end
      // exccode only moves on entry to COMMIT, then holds.
      if (state == FLUSH) exccode_q <= code_q;
    end
  end

  assign exccode = exccode_q;
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx        = state;
    activeexception = 1'b0;
    epc_we          = 1'b0;
    epc_wdata       = '0;
    set_exl         = 1'b0;
    clr_exl         = 1'b0;
    flush           = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    unique case (state)
      IDLE: begin
        if (take)      state_nx = FLUSH;
        else if (eret) state_nx = RET;
      end
      FLUSH: begin
        flush    = 1'b1;
        state_nx = COMMIT;
      end
      COMMIT: begin
        activeexception = 1'b1;
        redirect        = 1'b1;
        redirect_pc     = EXC_VECTOR;
        set_exl         = 1'b1;
        flush           = 1'b1;
        // Nested exception keeps the original EPC.
        epc_we          = ~status_exl;
        epc_wdata       = pc_q;
        state_nx        = IDLE;
      end
      RET: begin
        clr_exl     = 1'b1;
        redirect    = 1'b1;
        redirect_pc = epc_in;
        flush       = 1'b1;
        state_nx    = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // Reset squashes strobes in the cycle it is asserted.
    if (reset) begin
      activeexception = 1'b0;
      epc_we          = 1'b0;
      epc_wdata       = '0;
      set_exl         = 1'b0;
      clr_exl         = 1'b0;
      flush           = 1'b0;
      redirect        = 1'b0;
      redirect_pc     = '0;
    end
  end

endmodule
